// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter for a single-ported synchronous memory.
// Round-robin or loader-priority arbitration; one access in flight at a time.
module mem_arbiter #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ldr_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [AWIDTH-1:0] ldr_addr,
    input  logic [DWIDTH-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DWIDTH-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

    state_t            state, state_nxt;
    logic              last_ldr, last_ldr_nxt;
    logic              pick_ldr;
    logic              mem_en_nxt, mem_we_nxt;
    logic [AWIDTH-1:0] mem_addr_nxt;
    logic [DWIDTH-1:0] mem_wdata_nxt;
    logic              cpu_gnt_nxt, ldr_gnt_nxt;
    logic              cpu_rvalid_nxt, ldr_rvalid_nxt;
    logic [DWIDTH-1:0] cpu_rdata_nxt, ldr_rdata_nxt;

    // last_ldr also identifies the owner of the in-flight access
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            last_ldr   <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            last_ldr   <= last_ldr_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            ldr_gnt    <= ldr_gnt_nxt;
            cpu_rvalid <= cpu_rvalid_nxt;
            ldr_rvalid <= ldr_rvalid_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            ldr_rdata  <= ldr_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req || ldr_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = mem_we ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (ldr_mode)
            pick_ldr = ldr_req;
        else if (ldr_req && cpu_req)
            pick_ldr = ~last_ldr;
        else
            pick_ldr = ldr_req;
    end

    always_comb begin
        last_ldr_nxt   = last_ldr;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        cpu_gnt_nxt    = 1'b0;
        ldr_gnt_nxt    = 1'b0;
        cpu_rvalid_nxt = 1'b0;
        ldr_rvalid_nxt = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        ldr_rdata_nxt  = ldr_rdata;
        case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    last_ldr_nxt  = pick_ldr;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = pick_ldr ? ldr_we    : cpu_we;
                    mem_addr_nxt  = pick_ldr ? ldr_addr  : cpu_addr;
                    mem_wdata_nxt = pick_ldr ? ldr_wdata : cpu_wdata;
                    cpu_gnt_nxt   = ~pick_ldr;
                    ldr_gnt_nxt   = pick_ldr;
                end
            end
            ACCESS: begin
                // keep mem_we visible for the ACCESS exit decision only; strobe drops
                mem_we_nxt = 1'b0;
            end
            RD_WAIT: begin
                if (last_ldr) begin
                    ldr_rdata_nxt  = mem_rdata;
                    ldr_rvalid_nxt = 1'b1;
                end else begin
                    cpu_rdata_nxt  = mem_rdata;
                    cpu_rvalid_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

    localparam int unsigned AWIDTH = 5;
    localparam int unsigned DWIDTH = 8;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              ldr_mode = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AWIDTH-1:0] cpu_addr = '0;
    logic [DWIDTH-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rvalid;
    logic [DWIDTH-1:0] cpu_rdata;
    logic              ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AWIDTH-1:0] ldr_addr = '0;
    logic [DWIDTH-1:0] ldr_wdata = '0;
    logic              ldr_gnt, ldr_rvalid;
    logic [DWIDTH-1:0] ldr_rdata;
    logic              mem_en, mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata = '0;

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk(clk), .rst_(rst_), .ldr_mode(ldr_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port memory: read data appears the cycle after mem_en
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        tick();
        tick();
        rst_ = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_en"}, 32'(mem_en), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, " cpu_gnt"}, 32'(cpu_gnt), 0);
        check({tag, " ldr_gnt"}, 32'(ldr_gnt), 0);
        check({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 0);
        check({tag, " ldr_rvalid"}, 32'(ldr_rvalid), 0);
        check({tag, " cpu_rdata"}, 32'(cpu_rdata), 0);
        check({tag, " ldr_rdata"}, 32'(ldr_rdata), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = '0;
        mem[31] = 8'hA5;

        #1;
        check_all_zero("reset");
        do_reset();
        tick();
        check("idle no req mem_en", 32'(mem_en), 0);

        // Scenario 1: CPU write
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h3C;
        tick();
        check("s1 mem_en", 32'(mem_en), 1);
        check("s1 mem_we", 32'(mem_we), 1);
        check("s1 mem_addr", 32'(mem_addr), 32'h0A);
        check("s1 mem_wdata", 32'(mem_wdata), 32'h3C);
        check("s1 cpu_gnt", 32'(cpu_gnt), 1);
        check("s1 ldr_gnt", 32'(ldr_gnt), 0);
        cpu_req = 0;
        tick();
        check("s1 mem_en off", 32'(mem_en), 0);
        check("s1 cpu_gnt off", 32'(cpu_gnt), 0);
        check("s1 mem written", 32'(mem[10]), 32'h3C);

        // Scenario 2: loader read, CPU request raised during ACCESS is deferred
        ldr_req = 1; ldr_we = 0; ldr_addr = 5'h1F; ldr_wdata = 8'h77;
        tick();
        check("s2 ldr_gnt", 32'(ldr_gnt), 1);
        check("s2 mem_en", 32'(mem_en), 1);
        check("s2 mem_we", 32'(mem_we), 0);
        check("s2 mem_addr", 32'(mem_addr), 32'h1F);
        check("s2 mem_wdata", 32'(mem_wdata), 32'h77);
        ldr_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A;
        tick();
        check("s2 n2 ldr_rvalid", 32'(ldr_rvalid), 0);
        check("s2 n2 cpu_gnt", 32'(cpu_gnt), 0);
        check("s2 n2 mem_en", 32'(mem_en), 0);
        tick();
        check("s2 ldr_rvalid", 32'(ldr_rvalid), 1);
        check("s2 ldr_rdata", 32'(ldr_rdata), 32'hA5);
        check("s2 cpu_rvalid", 32'(cpu_rvalid), 0);
        check("s2 n3 cpu_gnt", 32'(cpu_gnt), 0);
        tick();
        check("s2 deferred cpu_gnt", 32'(cpu_gnt), 1);
        check("s2 ldr_rvalid off", 32'(ldr_rvalid), 0);
        cpu_req = 0;
        tick();
        tick();
        check("s2 cpu_rvalid", 32'(cpu_rvalid), 1);
        check("s2 cpu_rdata", 32'(cpu_rdata), 32'h3C);
        check("s2 ldr_rdata hold", 32'(ldr_rdata), 32'hA5);
        tick();
        check("s2 cpu_rvalid off", 32'(cpu_rvalid), 0);
        check("s2 cpu_rdata hold", 32'(cpu_rdata), 32'h3C);

        // Scenario 3: round-robin tie after reset, both reading continuously
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A;
        ldr_req = 1; ldr_we = 0; ldr_addr = 5'h1F;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("s3 cpu_gnt c%0d", i), 32'(cpu_gnt), 32'(i % 6 == 0));
            check($sformatf("s3 ldr_gnt c%0d", i), 32'(ldr_gnt), 32'(i % 6 == 3));
            check($sformatf("s3 cpu_rvalid c%0d", i), 32'(cpu_rvalid), 32'(i % 6 == 2));
            check($sformatf("s3 ldr_rvalid c%0d", i), 32'(ldr_rvalid), 32'(i % 6 == 5));
            if (i % 6 == 2) check("s3 cpu_rdata", 32'(cpu_rdata), 32'h3C);
            if (i % 6 == 5) check("s3 ldr_rdata", 32'(ldr_rdata), 32'hA5);
        end
        cpu_req = 0; ldr_req = 0;
        tick();
        check("s3 quiet", 32'({cpu_gnt, ldr_gnt}), 0);

        // Scenario 4: loader strict priority with both writing
        ldr_mode = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h01; cpu_wdata = 8'h11;
        ldr_req = 1; ldr_we = 1; ldr_addr = 5'h02; ldr_wdata = 8'h22;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("s4 cpu_gnt c%0d", i), 32'(cpu_gnt), 32'(i == 6));
            check($sformatf("s4 ldr_gnt c%0d", i), 32'(ldr_gnt), 32'(i == 0 || i == 2 || i == 4));
            if (i == 4) ldr_req = 0;
            if (i == 6) cpu_req = 0;
        end
        check("s4 cpu mem_addr", 32'(mem_addr), 32'h01);
        tick();
        // last-granted must follow a priority-mode grant
        ldr_req = 1;
        tick();
        check("s4 prio ldr_gnt", 32'(ldr_gnt), 1);
        ldr_req = 0;
        tick();
        ldr_mode = 0; cpu_req = 1; ldr_req = 1;
        tick();
        check("s4 rr after prio cpu_gnt", 32'(cpu_gnt), 1);
        check("s4 rr after prio ldr_gnt", 32'(ldr_gnt), 0);
        cpu_req = 0;
        tick();
        check("s4 gap gnt", 32'({cpu_gnt, ldr_gnt}), 0);
        tick();
        check("s4 rr ldr_gnt", 32'(ldr_gnt), 1);
        ldr_req = 0;
        tick();

        // Scenario 5: reset during RD_WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A;
        tick();
        check("s5 cpu_gnt", 32'(cpu_gnt), 1);
        cpu_req = 0;
        tick();
        rst_ = 0;
        #1;
        check_all_zero("s5 in reset");
        tick();
        tick();
        rst_ = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s5 post cpu_rvalid %0d", i), 32'(cpu_rvalid), 0);
            check($sformatf("s5 post ldr_rvalid %0d", i), 32'(ldr_rvalid), 0);
            check($sformatf("s5 post mem_en %0d", i), 32'(mem_en), 0);
        end
        ldr_req = 1; ldr_we = 0; ldr_addr = 5'h1F;
        tick();
        check("s5 ldr_gnt", 32'(ldr_gnt), 1);
        ldr_req = 0;
        tick();
        tick();
        check("s5 ldr_rvalid", 32'(ldr_rvalid), 1);
        check("s5 ldr_rdata", 32'(ldr_rdata), 32'hA5);
        tick();

        // Scenario 6: back-to-back CPU writes
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h03; cpu_wdata = 8'h55;
        tick();
        check("s6 first cpu_gnt", 32'(cpu_gnt), 1);
        check("s6 first mem_addr", 32'(mem_addr), 32'h03);
        cpu_req = 0;
        tick();
        check("s6 idle cpu_gnt", 32'(cpu_gnt), 0);
        cpu_req = 1; cpu_addr = 5'h04; cpu_wdata = 8'h66;
        tick();
        check("s6 second cpu_gnt", 32'(cpu_gnt), 1);
        check("s6 second mem_addr", 32'(mem_addr), 32'h04);
        check("s6 second mem_wdata", 32'(mem_wdata), 32'h66);
        cpu_req = 0;
        tick();
        tick();
        check("s6 mem[3]", 32'(mem[3]), 32'h55);
        check("s6 mem[4]", 32'(mem[4]), 32'h66);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
